// File: rtl/radio_link_if.sv
// radio_link_if: parallel-side and pin-side signals of the radio link.
//   enable/send/tx_data/receive/Rx : into the link
//   busy/Tx/rx_data/rx_valid/rx_err_frame/rx_err_parity : out of the link
// slave is the link's view. master is the surrounding node: the controller
// plus the PHY pin that drives Rx.
interface radio_link_if #(
  parameter int DATA_W = 8
);
  logic              enable;
  logic              send;
  logic [DATA_W-1:0] tx_data;
  logic              busy;
  logic              Tx;
  logic              receive;
  logic              Rx;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_err_frame;
  logic              rx_err_parity;

  modport master (
    output enable, send, tx_data, receive, Rx,
    input  busy, Tx, rx_data, rx_valid, rx_err_frame, rx_err_parity
  );

  modport slave (
    input  enable, send, tx_data, receive, Rx,
    output busy, Tx, rx_data, rx_valid, rx_err_frame, rx_err_parity
  );
endinterface

// File: rtl/radio_link.sv
// radio_link: framed serial transceiver (start, DATA_W bits LSB first,
// optional parity, one stop bit; CLKS_PER_BIT clocks per bit).
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : radio_link_if.slave
//              TX side  enable, send, tx_data -> busy, Tx
//              RX side  receive, Rx -> rx_data, rx_valid, rx_err_frame, rx_err_parity
// TX and RX are independent FSMs (full duplex); all outputs are registered.
module radio_link #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic          clk,
  input  logic          rst,
  radio_link_if.slave   bus
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  // ---------------- transmitter ----------------
  state_e            tx_st_q;
  logic [CW-1:0]     tx_cnt_q;
  logic [BW-1:0]     tx_idx_q;
  logic [DATA_W-1:0] tx_sh_q;
  logic              tx_par_q, tx_q, busy_q;
  logic              tx_par_d;

  assign tx_par_d = (^bus.tx_data) ^ (PARITY_ODD != 0);

  // Each state lasts one bit period; the line value for the next bit is
  // loaded at the period's last clock so Tx changes only on bit boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st_q  <= S_IDLE;
      tx_cnt_q <= '0;
      tx_idx_q <= '0;
      tx_sh_q  <= '0;
      tx_par_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else if (!bus.enable) begin
      tx_st_q  <= S_IDLE;
      tx_cnt_q <= '0;
      tx_idx_q <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else if (tx_st_q == S_IDLE) begin
      if (bus.send) begin
        tx_st_q  <= S_START;
        tx_sh_q  <= bus.tx_data;
        tx_par_q <= tx_par_d;
        tx_cnt_q <= '0;
        tx_q     <= 1'b0;
        busy_q   <= 1'b1;
      end
    end else if (tx_cnt_q != CNT_LAST) begin
      tx_cnt_q <= tx_cnt_q + 1'b1;
    end else begin
      tx_cnt_q <= '0;
      case (tx_st_q)
        S_START: begin
          tx_st_q  <= S_DATA;
          tx_idx_q <= '0;
          tx_q     <= tx_sh_q[0];
          tx_sh_q  <= tx_sh_q >> 1;
        end
        S_DATA: begin
          if (tx_idx_q == BIT_LAST) begin
            if (PARITY_EN != 0) begin
              tx_st_q <= S_PARITY;
              tx_q    <= tx_par_q;
            end else begin
              tx_st_q <= S_STOP;
              tx_q    <= 1'b1;
            end
          end else begin
            tx_idx_q <= tx_idx_q + 1'b1;
            tx_q     <= tx_sh_q[0];
            tx_sh_q  <= tx_sh_q >> 1;
          end
        end
        S_PARITY: begin
          tx_st_q <= S_STOP;
          tx_q    <= 1'b1;
        end
        default: begin
          tx_st_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------- receiver ----------------
  logic              rx_s1_q, rx_s2_q;
  state_e            rx_st_q;
  logic [CW-1:0]     rx_cnt_q;
  logic [BW-1:0]     rx_idx_q;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d, rx_data_q;
  logic              rx_par_q, rx_valid_q, rx_ferr_q, rx_perr_q;

  // Shift the new bit in at the top so the first received bit ends at bit 0.
  assign rx_sh_d = DATA_W'({rx_s2_q, rx_sh_q} >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= bus.Rx;
      rx_s2_q <= rx_s1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st_q    <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_sh_q    <= '0;
      rx_par_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_perr_q  <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (!bus.enable || !bus.receive) begin
        rx_st_q  <= S_IDLE;
        rx_cnt_q <= '0;
        rx_idx_q <= '0;
      end else begin
        case (rx_st_q)
          S_IDLE: begin
            // The low level was already present for one clock when it is
            // seen here, so the mid-bit count starts at 1.
            if (!rx_s2_q) begin
              rx_st_q  <= S_START;
              rx_cnt_q <= CW'(1);
            end
          end
          S_START: begin
            if (rx_cnt_q == CNT_HALF) begin
              rx_cnt_q <= '0;
              rx_idx_q <= '0;
              rx_st_q  <= rx_s2_q ? S_IDLE : S_DATA;
            end else begin
              rx_cnt_q <= rx_cnt_q + 1'b1;
            end
          end
          default: begin
            if (rx_cnt_q != CNT_LAST) begin
              rx_cnt_q <= rx_cnt_q + 1'b1;
            end else begin
              rx_cnt_q <= '0;
              case (rx_st_q)
                S_DATA: begin
                  rx_sh_q <= rx_sh_d;
                  if (rx_idx_q == BIT_LAST)
                    rx_st_q <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                  else
                    rx_idx_q <= rx_idx_q + 1'b1;
                end
                S_PARITY: begin
                  rx_par_q <= rx_s2_q;
                  rx_st_q  <= S_STOP;
                end
                default: begin
                  rx_st_q    <= S_IDLE;
                  rx_data_q  <= rx_sh_q;
                  rx_valid_q <= 1'b1;
                  rx_ferr_q  <= !rx_s2_q;
                  rx_perr_q  <= (PARITY_EN != 0) &&
                                (rx_par_q != ((^rx_sh_q) ^ (PARITY_ODD != 0)));
                end
              endcase
            end
          end
        endcase
      end
    end
  end

  assign bus.busy          = busy_q;
  assign bus.Tx            = tx_q;
  assign bus.rx_data       = rx_data_q;
  assign bus.rx_valid      = rx_valid_q;
  assign bus.rx_err_frame  = rx_ferr_q;
  assign bus.rx_err_parity = rx_perr_q;
endmodule

// File: tb/tb_radio_link.sv
// tb_radio_link: directed bench for radio_link. An 8-bit, 4 clk/bit, even
// parity instance is checked every cycle against a frame-level model; a
// 12-bit, 3 clk/bit, no-parity instance runs one loopback word.
module tb_radio_link;
  localparam int CPB = 4;
  localparam int FB  = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic loop8  = 1'b1;
  logic ext_rx = 1'b1;
  logic chk_en = 1'b0;

  radio_link_if #(.DATA_W(8))  if8();
  radio_link_if #(.DATA_W(12)) if12();

  assign if8.Rx  = loop8 ? if8.Tx : ext_rx;
  assign if12.Rx = if12.Tx;

  radio_link #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0))
    u8 (.clk(clk), .rst(rst), .bus(if8));
  radio_link #(.DATA_W(12), .CLKS_PER_BIT(3), .PARITY_EN(0), .PARITY_ODD(0))
    u12 (.clk(clk), .rst(rst), .bus(if12));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---- transmit model: a frame is a bit vector, time since accept picks the bit
  function automatic logic [FB-1:0] frame_of(input logic [7:0] d);
    return {1'b1, ^d, d, 1'b0};
  endfunction

  logic          m_busy  = 1'b0;
  logic          m_rst   = 1'b0;
  int            m_t     = 0;
  logic [FB-1:0] m_frame = '1;

  always @(posedge clk) begin
    m_rst <= rst;
    if (rst || !if8.enable) m_busy <= 1'b0;
    else if (!m_busy) begin
      if (if8.send) begin
        m_busy  <= 1'b1;
        m_t     <= 0;
        m_frame <= frame_of(if8.tx_data);
      end
    end else begin
      m_t <= m_t + 1;
      if (m_t == FB*CPB - 1) m_busy <= 1'b0;
    end
  end

  // ---- receive model: ordered list of frames that must complete
  logic [7:0] e_data [32];
  logic       e_fe   [32];
  logic       e_pe   [32];
  int         n_push = 0;
  int         n_pop  = 0;
  logic [7:0] m_rxd  = 8'h00;
  logic       m_fe   = 1'b0;
  logic       m_pe   = 1'b0;

  task automatic expect_rx(input logic [7:0] d, input logic fe, input logic pe);
    e_data[n_push] = d;
    e_fe[n_push]   = fe;
    e_pe[n_push]   = pe;
    n_push++;
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (m_rst) begin
          m_rxd = 8'h00; m_fe = 1'b0; m_pe = 1'b0;
        end
        if (if8.rx_valid) begin
          check("rx_valid_expected", n_pop < n_push, 1);
          if (n_pop < n_push) begin
            m_rxd = e_data[n_pop]; m_fe = e_fe[n_pop]; m_pe = e_pe[n_pop];
            n_pop++;
          end
        end
        check("busy", if8.busy, m_busy);
        check("tx", if8.Tx, m_busy ? m_frame[m_t/CPB] : 1'b1);
        check("rx_data", if8.rx_data, m_rxd);
        check("rx_err_frame", if8.rx_err_frame, m_fe);
        check("rx_err_parity", if8.rx_err_parity, m_pe);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_one(input logic [7:0] d);
    if8.tx_data = d;
    if8.send    = 1'b1;
    tick(1);
    if8.send    = 1'b0;
  endtask

  // Called on the first negedge after the accepting edge; seq[i] is frame bit i.
  task automatic watch_frame(input logic [FB-1:0] seq, output int nb);
    int c = 0;
    while (if8.busy && c < 200) begin
      if (c % CPB == 1 && c / CPB < FB) check("tx_seq", if8.Tx, seq[c/CPB]);
      c++;
      tick(1);
    end
    nb = c;
  endtask

  task automatic wait_rx(input int bound);
    int k = 0;
    while (n_pop != n_push && k < bound) begin
      k++;
      tick(1);
    end
    check("rx_frames_done", n_pop, n_push);
  endtask

  task automatic drive_frame(input logic [FB-1:0] bits);
    for (int i = 0; i < FB; i++) begin
      ext_rx = bits[i];
      tick(CPB);
    end
    ext_rx = 1'b1;
  endtask

  initial begin
    int nb, gap, c, v, perr_seen;
    if8.enable = 0;  if8.send = 0;  if8.tx_data = '0;  if8.receive = 0;
    if12.enable = 0; if12.send = 0; if12.tx_data = '0; if12.receive = 0;
    fork compare_loop(); join_none
    tick(3);
    check("rst_busy", if8.busy, 0);
    check("rst_tx", if8.Tx, 1);
    check("rst_rx_data", if8.rx_data, 0);
    check("rst_rx_valid", if8.rx_valid, 0);
    check("rst_err_frame", if8.rx_err_frame, 0);
    check("rst_err_parity", if8.rx_err_parity, 0);
    check("rst_tx12", if12.Tx, 1);
    rst = 1'b0; if8.enable = 1'b1; if8.receive = 1'b1; chk_en = 1'b1;
    tick(2);

    // single loopback frame
    expect_rx(8'hAA, 0, 0);
    send_one(8'hAA);
    watch_frame(11'b10101010100, nb);
    check("busy_len_aa", nb, 44);
    wait_rx(30);
    check("rx_data_aa", if8.rx_data, 8'hAA);

    // back-to-back with send held
    tick(3);
    expect_rx(8'h01, 0, 0);
    expect_rx(8'hFF, 0, 0);
    if8.tx_data = 8'h01; if8.send = 1'b1;
    tick(1);
    if8.tx_data = 8'hFF;
    watch_frame(11'b11000000010, nb);
    check("busy_len_01", nb, 44);
    gap = 0;
    while (!if8.busy && gap < 10) begin gap++; tick(1); end
    check("idle_gap", gap, 1);
    if8.send = 1'b0;
    watch_frame(11'b10111111110, nb);
    check("busy_len_ff", nb, 44);
    wait_rx(30);
    check("rx_data_ff", if8.rx_data, 8'hFF);

    // externally driven frames with errors
    tick(5); loop8 = 1'b0; tick(5);
    expect_rx(8'h5A, 0, 1);
    drive_frame(11'b11010110100);
    wait_rx(30);
    check("perr_5a", if8.rx_err_parity, 1);
    check("perr_5a_data", if8.rx_data, 8'h5A);
    tick(5);
    expect_rx(8'h5A, 1, 0);
    drive_frame(11'b00010110100);
    wait_rx(30);
    check("ferr_5a", if8.rx_err_frame, 1);
    check("ferr_5a_perr", if8.rx_err_parity, 0);

    // one-cycle glitch in idle
    tick(10);
    ext_rx = 1'b0; tick(1); ext_rx = 1'b1;
    tick(20);
    check("glitch_rx_data", if8.rx_data, 8'h5A);
    check("glitch_no_valid", n_pop, n_push);

    // enable dropped at cycle 20 of a transmit
    loop8 = 1'b1; tick(3);
    send_one(8'h3C);
    tick(20);
    if8.enable = 1'b0;
    tick(1);
    check("en_abort_tx", if8.Tx, 1);
    check("en_abort_busy", if8.busy, 0);
    if8.enable = 1'b1;
    tick(5);

    // receive dropped mid-frame
    send_one(8'hC3);
    tick(20);
    if8.receive = 1'b0;
    c = 0;
    while (if8.busy && c < 100) begin c++; tick(1); end
    tick(5);
    if8.receive = 1'b1;
    tick(10);
    check("rx_abort_no_valid", n_pop, n_push);
    check("rx_abort_data", if8.rx_data, 8'h5A);

    // reset mid-frame
    send_one(8'h96);
    tick(15);
    rst = 1'b1;
    tick(1);
    check("mid_rst_busy", if8.busy, 0);
    check("mid_rst_tx", if8.Tx, 1);
    check("mid_rst_rx_data", if8.rx_data, 0);
    check("mid_rst_rx_valid", if8.rx_valid, 0);
    check("mid_rst_err_frame", if8.rx_err_frame, 0);
    check("mid_rst_err_parity", if8.rx_err_parity, 0);
    rst = 1'b0;
    tick(5);

    // 12-bit, 3 clk/bit, no parity, loopback
    if12.enable = 1'b1; if12.receive = 1'b1;
    tick(3);
    if12.tx_data = 12'hABC; if12.send = 1'b1;
    tick(1);
    if12.send = 1'b0;
    c = 0; v = 0; perr_seen = 0;
    while (if12.busy && c < 200) begin
      c++;
      v += int'(if12.rx_valid);
      perr_seen |= int'(if12.rx_err_parity);
      tick(1);
    end
    check("busy_len_12", c, 42);
    for (int k = 0; k < 40; k++) begin
      v += int'(if12.rx_valid);
      perr_seen |= int'(if12.rx_err_parity);
      tick(1);
    end
    check("rx12_pulses", v, 1);
    check("rx12_data", if12.rx_data, 12'hABC);
    check("rx12_perr", perr_seen, 0);
    check("rx12_ferr", if12.rx_err_frame, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
